bfpu_operand_aligner: RTL

// - Upstream stage of bfpu: pairs two independently arriving bit-vector operand streams.
// - Each stream is buffered in its own FIFO; one aligned pair is issued per cycle,

---
 rtl/bfpu_operand_aligner.sv | 117 +++++++++++
 1 files changed

// File: rtl/bfpu_operand_aligner.sv
// Pairs two independently arriving operand streams through per-side FIFOs and issues aligned pairs to bfpu.
// Optional statistics counters (pair_count, skew_cycles) are enabled by defining BFPU_ALIGN_STATS_EN.
module bfpu_operand_aligner #(
  parameter int BIT_VEC_SIZE = 512,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIT_VEC_SIZE-1:0] in_1,
  input  logic                    valid_in_1,
  output logic                    ready_in_1,
  input  logic [2:0]              op_in,
  input  logic                    choice_in,
  input  logic [BIT_VEC_SIZE-1:0] in_2,
  input  logic                    valid_in_2,
  output logic                    ready_in_2,
  input  logic                    stall,
  input  logic                    flush,
  output logic [BIT_VEC_SIZE-1:0] out_1,
  output logic [BIT_VEC_SIZE-1:0] out_2,
  output logic [2:0]              opcode_out,
  output logic                    choice_out,
`ifdef BFPU_ALIGN_STATS_EN
  output logic [31:0]             pair_count,
  output logic [31:0]             skew_cycles,
`endif
  output logic                    valid_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int A_W   = BIT_VEC_SIZE + 4;

  logic [A_W-1:0]          mem_1 [FIFO_DEPTH];
  logic [BIT_VEC_SIZE-1:0] mem_2 [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_1, rd_ptr_1, wr_ptr_2, rd_ptr_2;
  logic [CNT_W-1:0] count_1, count_2;
  logic             push_1, push_2, pop;
  logic [A_W-1:0]   head_1;

  // Flow control comes from the registered count only, so a full side never accepts, even while popping.
  assign ready_in_1 = (count_1 != CNT_W'(FIFO_DEPTH));
  assign ready_in_2 = (count_2 != CNT_W'(FIFO_DEPTH));

  assign push_1 = valid_in_1 & ready_in_1 & ~flush;
  assign push_2 = valid_in_2 & ready_in_2 & ~flush;
  assign pop    = (count_1 != '0) & (count_2 != '0) & ~stall & ~flush;
  assign head_1 = mem_1[rd_ptr_1];

  always_ff @(posedge clk) begin
    if (push_1) mem_1[wr_ptr_1] <= {op_in, choice_in, in_1};
    if (push_2) mem_2[wr_ptr_2] <= in_2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_1 <= '0;
      rd_ptr_1 <= '0;
      wr_ptr_2 <= '0;
      rd_ptr_2 <= '0;
      count_1  <= '0;
      count_2  <= '0;
    end else if (flush) begin
      wr_ptr_1 <= '0;
      rd_ptr_1 <= '0;
      wr_ptr_2 <= '0;
      rd_ptr_2 <= '0;
      count_1  <= '0;
      count_2  <= '0;
    end else begin
      if (push_1) wr_ptr_1 <= wr_ptr_1 + PTR_W'(1);
      if (push_2) wr_ptr_2 <= wr_ptr_2 + PTR_W'(1);
      if (pop) begin
        rd_ptr_1 <= rd_ptr_1 + PTR_W'(1);
        rd_ptr_2 <= rd_ptr_2 + PTR_W'(1);
      end
      count_1 <= count_1 + CNT_W'(push_1) - CNT_W'(pop);
      count_2 <= count_2 + CNT_W'(push_2) - CNT_W'(pop);
    end
  end

  // Data outputs hold their last issued pair; only valid_out drops when nothing issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_1      <= '0;
      out_2      <= '0;
      opcode_out <= '0;
      choice_out <= 1'b0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= pop;
      if (pop) begin
        out_1      <= head_1[BIT_VEC_SIZE-1:0];
        choice_out <= head_1[BIT_VEC_SIZE];
        opcode_out <= head_1[A_W-1:BIT_VEC_SIZE+1];
        out_2      <= mem_2[rd_ptr_2];
      end
    end
  end

`ifdef BFPU_ALIGN_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_count  <= '0;
      skew_cycles <= '0;
    end else if (flush) begin
      pair_count  <= '0;
      skew_cycles <= '0;
    end else begin
      if (pop) pair_count <= pair_count + 32'd1;
      if (((count_1 != '0) ^ (count_2 != '0)) && !stall) skew_cycles <= skew_cycles + 32'd1;
    end
  end
`endif

endmodule
